// File: rtl/rob_head_if.sv
// Bundle of the reorder-buffer dispatch, writeback and commit signals.
// master is the buffer itself; slave is the core around it (dispatch, ALU, LSB, commit).
interface rob_head_if #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned INSTR_ID_W = 8,
  parameter int unsigned ADDR_W     = 32
);
  logic                  alloc_en_in;
  logic [INSTR_ID_W-1:0] alloc_instr_id_in;
  logic [4:0]            alloc_rd_in;
  logic [IDX_W-1:0]      alloc_tag_out;
  logic                  rob_full_out;

  logic                  alu_wb_en_in;
  logic [IDX_W-1:0]      alu_wb_tag_in;
  logic [31:0]           alu_wb_value_in;
  logic                  alu_wb_jump_en_in;
  logic [ADDR_W-1:0]     alu_wb_jump_a_in;

  logic                  lsb_wb_en_in;
  logic [IDX_W-1:0]      lsb_wb_tag_in;
  logic [31:0]           lsb_wb_value_in;

  logic                  rob_to_commit_en_out;
  logic [INSTR_ID_W-1:0] instr_id_out;
  logic                  jump_en_out;
  logic [ADDR_W-1:0]     jump_a_out;
  logic [4:0]            commit_rd_out;
  logic [31:0]           commit_value_out;
  logic [IDX_W-1:0]      commit_tag_out;
  logic                  clear_branch_in;

  modport master (
    input  alloc_en_in, alloc_instr_id_in, alloc_rd_in,
    output alloc_tag_out, rob_full_out,
    input  alu_wb_en_in, alu_wb_tag_in, alu_wb_value_in, alu_wb_jump_en_in, alu_wb_jump_a_in,
    input  lsb_wb_en_in, lsb_wb_tag_in, lsb_wb_value_in,
    output rob_to_commit_en_out, instr_id_out, jump_en_out, jump_a_out,
    output commit_rd_out, commit_value_out, commit_tag_out,
    input  clear_branch_in
  );

  modport slave (
    output alloc_en_in, alloc_instr_id_in, alloc_rd_in,
    input  alloc_tag_out, rob_full_out,
    output alu_wb_en_in, alu_wb_tag_in, alu_wb_value_in, alu_wb_jump_en_in, alu_wb_jump_a_in,
    output lsb_wb_en_in, lsb_wb_tag_in, lsb_wb_value_in,
    input  rob_to_commit_en_out, instr_id_out, jump_en_out, jump_a_out,
    input  commit_rd_out, commit_value_out, commit_tag_out,
    output clear_branch_in
  );
endinterface

// File: rtl/rob_head.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order retirement
// as a registered one-cycle commit pulse; a branch clear flushes everything.
module rob_head #(
  parameter int unsigned ROB_DEPTH  = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned INSTR_ID_W = 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  rob_head_if.master bus
);
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]  busy;
  logic [ROB_DEPTH-1:0]  ready;
  logic [INSTR_ID_W-1:0] ent_instr_id [ROB_DEPTH];
  logic [4:0]            ent_rd       [ROB_DEPTH];
  logic [31:0]           ent_value    [ROB_DEPTH];
  logic                  ent_jump_en  [ROB_DEPTH];
  logic [ADDR_W-1:0]     ent_jump_a   [ROB_DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  logic                  commit_en;
  logic [INSTR_ID_W-1:0] commit_instr_id;
  logic                  commit_jump_en;
  logic [ADDR_W-1:0]     commit_jump_a;
  logic [4:0]            commit_rd;
  logic [31:0]           commit_value;
  logic [IDX_W-1:0]      commit_tag;

  logic full;
  logic advance;
  logic do_alloc;
  logic do_retire;
  logic cnt_inc;
  logic alu_hit;
  logic lsb_hit;

  always_comb begin
    full      = (count == DEPTH_CNT);
    advance   = rdy_in && !bus.clear_branch_in;
    do_retire = busy[head] && ready[head];
    do_alloc  = bus.alloc_en_in && !full;
    // A request arriving alongside a retire keeps count unchanged even when full,
    // although the full flag still blocks the entry write itself.
    cnt_inc   = bus.alloc_en_in && (!full || do_retire);
    alu_hit   = bus.alu_wb_en_in && busy[bus.alu_wb_tag_in] && !ready[bus.alu_wb_tag_in];
    lsb_hit   = bus.lsb_wb_en_in && busy[bus.lsb_wb_tag_in] && !ready[bus.lsb_wb_tag_in]
                && !(alu_hit && (bus.alu_wb_tag_in == bus.lsb_wb_tag_in));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.clear_branch_in) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + 1'b1;
      end
      if (lsb_hit) ready[bus.lsb_wb_tag_in] <= 1'b1;
      if (alu_hit) ready[bus.alu_wb_tag_in] <= 1'b1;
      if (do_retire) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + (IDX_W+1)'(cnt_inc) - (IDX_W+1)'(do_retire);
    end
  end

  // Payload needs no reset: it is only observed through busy/ready-qualified retirement.
  always_ff @(posedge clk_in) begin
    if (advance) begin
      if (do_alloc) begin
        ent_instr_id[tail] <= bus.alloc_instr_id_in;
        ent_rd[tail]       <= bus.alloc_rd_in;
        ent_jump_en[tail]  <= 1'b0;
        ent_jump_a[tail]   <= '0;
      end
      if (lsb_hit) ent_value[bus.lsb_wb_tag_in] <= bus.lsb_wb_value_in;
      if (alu_hit) begin
        ent_value[bus.alu_wb_tag_in]   <= bus.alu_wb_value_in;
        ent_jump_en[bus.alu_wb_tag_in] <= bus.alu_wb_jump_en_in;
        ent_jump_a[bus.alu_wb_tag_in]  <= bus.alu_wb_jump_a_in;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      commit_en       <= 1'b0;
      commit_instr_id <= '0;
      commit_jump_en  <= 1'b0;
      commit_jump_a   <= '0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_tag      <= '0;
    end else if (bus.clear_branch_in) begin
      commit_en       <= 1'b0;
      commit_instr_id <= '0;
      commit_jump_en  <= 1'b0;
      commit_jump_a   <= '0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_tag      <= '0;
    end else if (!rdy_in) begin
      commit_en <= 1'b0;
    end else if (do_retire) begin
      commit_en       <= 1'b1;
      commit_instr_id <= ent_instr_id[head];
      commit_jump_en  <= ent_jump_en[head];
      commit_jump_a   <= ent_jump_a[head];
      commit_rd       <= ent_rd[head];
      commit_value    <= ent_value[head];
      commit_tag      <= head;
    end else begin
      commit_en <= 1'b0;
    end
  end

  assign bus.alloc_tag_out        = tail;
  assign bus.rob_full_out         = full;
  assign bus.rob_to_commit_en_out = commit_en;
  assign bus.instr_id_out         = commit_instr_id;
  assign bus.jump_en_out          = commit_jump_en;
  assign bus.jump_a_out           = commit_jump_a;
  assign bus.commit_rd_out        = commit_rd;
  assign bus.commit_value_out     = commit_value;
  assign bus.commit_tag_out       = commit_tag;
endmodule

// File: tb/tb_rob_head.sv
// Bench for rob_head: directed scenarios plus random traffic, all compared each
// cycle against a queue-based model of the buffer's architectural behaviour.
module tb_rob_head;
  logic clk;
  logic rst;
  logic rdy;

  rob_head_if #(.IDX_W(4), .INSTR_ID_W(8), .ADDR_W(32)) bus ();

  rob_head #(.ROB_DEPTH(16), .IDX_W(4), .INSTR_ID_W(8), .ADDR_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit run_chk  = 0;

  typedef struct {
    int          tag;
    logic [7:0]  id;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          rdy;
    bit          jen;
    logic [31:0] ja;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  int   m_count;
  bit          e_en;
  logic [7:0]  e_id;
  logic [4:0]  e_rd;
  logic [31:0] e_val;
  int          e_tag;
  bit          e_jen;
  logic [31:0] e_ja;

  int          log_tag[$];
  logic [31:0] log_val[$];
  bit          log_jen[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0; m_count = 0;
    e_en = 0; e_id = '0; e_rd = '0; e_val = '0; e_tag = 0; e_jen = 0; e_ja = '0;
  endtask

  // Architectural effect of one clock edge, using the inputs held across it.
  task automatic model_step();
    bit ret, fl;
    ent_t e;
    if (bus.clear_branch_in) begin
      model_reset();
    end else if (!rdy) begin
      e_en = 0;
    end else begin
      ret = (q.size() > 0) && q[0].rdy;
      fl  = (m_count == 16);
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (!e.rdy) begin
          if (bus.lsb_wb_en_in && int'(bus.lsb_wb_tag_in) == e.tag) begin
            e.val = bus.lsb_wb_value_in; e.rdy = 1;
          end
          if (bus.alu_wb_en_in && int'(bus.alu_wb_tag_in) == e.tag) begin
            e.val = bus.alu_wb_value_in; e.jen = bus.alu_wb_jump_en_in;
            e.ja = bus.alu_wb_jump_a_in; e.rdy = 1;
          end
        end
        q[i] = e;
      end
      if (ret) begin
        e = q.pop_front();
        e_en = 1; e_id = e.id; e_rd = e.rd; e_val = e.val; e_tag = e.tag;
        e_jen = e.jen; e_ja = e.ja;
      end else begin
        e_en = 0;
      end
      if (bus.alloc_en_in && !fl) begin
        e = '{tag: m_tail, id: bus.alloc_instr_id_in, rd: bus.alloc_rd_in,
              val: 32'h0, rdy: 0, jen: 0, ja: 32'h0};
        q.push_back(e);
        m_tail = (m_tail + 1) % 16;
      end
      if (bus.alloc_en_in && (!fl || ret)) m_count++;
      if (ret) m_count--;
    end
  endtask

  always @(negedge clk) begin
    if (run_chk && !rst) begin
      check("alloc_tag", bus.alloc_tag_out, m_tail);
      check("rob_full", bus.rob_full_out, m_count == 16);
      check("commit_en", bus.rob_to_commit_en_out, e_en);
      check("instr_id", bus.instr_id_out, e_id);
      check("commit_rd", bus.commit_rd_out, e_rd);
      check("commit_value", bus.commit_value_out, e_val);
      check("commit_tag", bus.commit_tag_out, e_tag);
      check("jump_en", bus.jump_en_out, e_jen);
      check("jump_a", bus.jump_a_out, e_ja);
      if (bus.rob_to_commit_en_out) begin
        log_tag.push_back(int'(bus.commit_tag_out));
        log_val.push_back(bus.commit_value_out);
        log_jen.push_back(bus.jump_en_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rdy = 1;
    bus.alloc_en_in = 0; bus.alloc_instr_id_in = '0; bus.alloc_rd_in = '0;
    bus.alu_wb_en_in = 0; bus.alu_wb_tag_in = '0; bus.alu_wb_value_in = '0;
    bus.alu_wb_jump_en_in = 0; bus.alu_wb_jump_a_in = '0;
    bus.lsb_wb_en_in = 0; bus.lsb_wb_tag_in = '0; bus.lsb_wb_value_in = '0;
    bus.clear_branch_in = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #2;
    rst = 0;
  endtask

  task automatic alloc1(input logic [7:0] id, input logic [4:0] rd);
    bus.alloc_en_in = 1; bus.alloc_instr_id_in = id; bus.alloc_rd_in = rd;
    tick();
    bus.alloc_en_in = 0;
  endtask

  task automatic wba(input int tag, input logic [31:0] val, input bit jen, input logic [31:0] ja);
    bus.alu_wb_en_in = 1; bus.alu_wb_tag_in = 4'(tag); bus.alu_wb_value_in = val;
    bus.alu_wb_jump_en_in = jen; bus.alu_wb_jump_a_in = ja;
    tick();
    bus.alu_wb_en_in = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nxt, after;
    bit done, saw4;
    rst = 1;
    idle();
    model_reset();
    #2;
    check("reset_tag", bus.alloc_tag_out, 0);
    check("reset_full", bus.rob_full_out, 0);
    check("reset_en", bus.rob_to_commit_en_out, 0);
    #10;
    rst = 0;
    run_chk = 1;

    // Mid-stream asynchronous reset with five live entries
    for (int i = 0; i < 5; i++) alloc1(8'(i + 1), 5'(i));
    wba(0, 32'hDEAD, 0, 32'h0);
    tick();
    check("pre_rst_tag", bus.alloc_tag_out, 5);
    #2;
    rst = 1;
    model_reset();
    #1;
    check("async_rst_tag", bus.alloc_tag_out, 0);
    check("async_rst_full", bus.rob_full_out, 0);
    check("async_rst_en", bus.rob_to_commit_en_out, 0);
    check("async_rst_value", bus.commit_value_out, 0);
    #2;
    rst = 0;
    check("first_tag_after_rst", bus.alloc_tag_out, 0);
    alloc1(8'h40, 5'd1);

    // In-order retire with writeback order 2,0,1
    do_reset();
    alloc1(8'd10, 5'd1); alloc1(8'd11, 5'd2); alloc1(8'd12, 5'd3);
    log_tag.delete(); log_val.delete(); log_jen.delete();
    wba(2, 32'hA2, 0, 32'h0);
    wba(0, 32'hA0, 0, 32'h0);
    wba(1, 32'hA1, 0, 32'h0);
    check("s2_first_pulse_en", bus.rob_to_commit_en_out, 1);
    check("s2_first_pulse_tag", bus.commit_tag_out, 0);
    repeat (4) tick();
    check("s2_pulse_count", log_tag.size(), 3);
    if (log_tag.size() == 3) begin
      check("s2_order0", log_tag[0], 0); check("s2_val0", log_val[0], 32'hA0);
      check("s2_order1", log_tag[1], 1); check("s2_val1", log_val[1], 32'hA1);
      check("s2_order2", log_tag[2], 2); check("s2_val2", log_val[2], 32'hA2);
    end

    // Full, ignored 17th allocation, wrap, allocate-while-retiring when full
    do_reset();
    log_tag.delete(); log_val.delete(); log_jen.delete();
    for (int i = 0; i < 16; i++) alloc1(8'(8'h20 + i), 5'(i));
    check("s3_full", bus.rob_full_out, 1);
    alloc1(8'h99, 5'd7);
    check("s3_17th_tag", bus.alloc_tag_out, 0);
    check("s3_17th_full", bus.rob_full_out, 1);
    wba(0, 32'h100, 0, 32'h0);
    tick();
    check("s3_full_clear", bus.rob_full_out, 0);
    check("s3_wrap_tag", bus.alloc_tag_out, 0);
    alloc1(8'h55, 5'd9);
    check("s3_full_again", bus.rob_full_out, 1);
    wba(1, 32'h101, 0, 32'h0);
    bus.alloc_en_in = 1; bus.alloc_instr_id_in = 8'h77;
    tick();
    bus.alloc_en_in = 0;
    check("s3_count_stays16", bus.rob_full_out, 1);
    check("s3_alloc_dropped", bus.alloc_tag_out, 1);
    for (int t = 2; t < 16; t++) wba(t, 32'(32'h100 + t), 0, 32'h0);
    wba(0, 32'h200, 0, 32'h0);
    repeat (4) tick();
    check("s3_pulse_count", log_tag.size(), 17);
    if (log_tag.size() == 17) begin
      check("s3_before_wrap", log_tag[15], 15);
      check("s3_wrapped_tag", log_tag[16], 0);
      check("s3_wrapped_val", log_val[16], 32'h200);
    end

    // Flush during a taken branch's commit pulse
    do_reset();
    for (int i = 0; i < 8; i++) alloc1(8'(i), 5'(i));
    log_tag.delete(); log_val.delete(); log_jen.delete();
    nxt = 0; done = 0; after = 0;
    for (int c = 0; c < 30 && after < 3; c++) begin
      if (nxt < 8) begin
        bus.alu_wb_en_in = 1; bus.alu_wb_tag_in = 4'(nxt);
        bus.alu_wb_value_in = 32'(32'h300 + nxt);
        bus.alu_wb_jump_en_in = (nxt == 3);
        bus.alu_wb_jump_a_in = (nxt == 3) ? 32'h1234 : 32'h0;
        nxt++;
      end else begin
        bus.alu_wb_en_in = 0;
      end
      if (!done && bus.rob_to_commit_en_out && bus.commit_tag_out == 4'd3) begin
        bus.clear_branch_in = 1;
        done = 1;
      end
      tick();
      bus.clear_branch_in = 0;
      if (done) after++;
    end
    bus.alu_wb_en_in = 0;
    check("s4_pulse3_seen", done, 1);
    saw4 = 0;
    foreach (log_tag[i]) if (log_tag[i] == 4) saw4 = 1;
    check("s4_no_tag4", saw4, 0);
    check("s4_last_tag", log_tag[$], 3);
    check("s4_last_jump", log_jen[$], 1);
    check("s4_flush_tag", bus.alloc_tag_out, 0);
    check("s4_flush_full", bus.rob_full_out, 0);
    check("s4_flush_en", bus.rob_to_commit_en_out, 0);
    alloc1(8'h61, 5'd4);
    check("s4_next_tag", bus.commit_tag_out, 0);

    // Same-tag writeback on both ports: ALU wins
    do_reset();
    alloc1(8'h05, 5'd1);
    log_tag.delete(); log_val.delete(); log_jen.delete();
    bus.alu_wb_en_in = 1; bus.alu_wb_tag_in = 4'd0; bus.alu_wb_value_in = 32'h11;
    bus.lsb_wb_en_in = 1; bus.lsb_wb_tag_in = 4'd0; bus.lsb_wb_value_in = 32'h22;
    tick();
    idle();
    repeat (2) tick();
    check("s5_pulse_count", log_val.size(), 1);
    check("s5_alu_wins", log_val[0], 32'h11);

    // Stall with a ready head, then flush during a stall
    do_reset();
    alloc1(8'h0A, 5'd2);
    log_tag.delete(); log_val.delete(); log_jen.delete();
    wba(0, 32'h44, 0, 32'h0);
    rdy = 0;
    repeat (3) tick();
    check("s6_no_pulse_stalled", log_val.size(), 0);
    rdy = 1;
    tick();
    check("s6_pulse_after_stall", bus.rob_to_commit_en_out, 1);
    tick();
    check("s6_one_pulse", log_val.size(), 1);
    alloc1(8'h0B, 5'd3); alloc1(8'h0C, 5'd4);
    rdy = 0; bus.clear_branch_in = 1;
    tick();
    bus.clear_branch_in = 0; rdy = 1;
    check("s6_stall_flush_tag", bus.alloc_tag_out, 0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom % 8) != 0;
      bus.alloc_en_in = ($urandom % 3) != 0;
      bus.alloc_instr_id_in = 8'($urandom);
      bus.alloc_rd_in = 5'($urandom);
      bus.alu_wb_en_in = $urandom % 2;
      bus.alu_wb_tag_in = (q.size() > 0 && $urandom % 2) ? 4'(q[$urandom % q.size()].tag) : 4'($urandom);
      bus.alu_wb_value_in = $urandom;
      bus.alu_wb_jump_en_in = $urandom % 2;
      bus.alu_wb_jump_a_in = $urandom;
      bus.lsb_wb_en_in = $urandom % 2;
      bus.lsb_wb_tag_in = (q.size() > 0 && $urandom % 2) ? 4'(q[$urandom % q.size()].tag) : 4'($urandom);
      bus.lsb_wb_value_in = $urandom;
      bus.clear_branch_in = ($urandom % 150) == 0;
      tick();
    end
    idle();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
